// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for the N-master AXI4 read arbiter: per-master AR/R upstream
// signals and the single shared AR/R downstream port.
interface axi_rd_arbiter_if #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [NUM_M-1:0]              s_arvalid;
    logic [NUM_M-1:0]              s_arready;
    logic [NUM_M*(ADDR_W+13)-1:0]  s_ar_pld;
    logic [NUM_M-1:0]              s_rvalid;
    logic [NUM_M-1:0]              s_rready;
    logic [DATA_W+2:0]             s_r_pld;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [ID_W-1:0]               m_arid;
    logic [ADDR_W+12:0]            m_ar_pld;
    logic                          m_rvalid;
    logic                          m_rready;
    logic [ID_W-1:0]               m_rid;
    logic [DATA_W+2:0]             m_r_pld;

    // Arbiter view: it is the master of the shared downstream port.
    modport master (
        input  s_arvalid, s_ar_pld, s_rready,
        input  m_arready, m_rvalid, m_rid, m_r_pld,
        output s_arready, s_rvalid, s_r_pld,
        output m_arvalid, m_arid, m_ar_pld, m_rready
    );

    // Surrounding system view: upstream masters plus the downstream slave.
    modport slave (
        output s_arvalid, s_ar_pld, s_rready,
        output m_arready, m_rvalid, m_rid, m_r_pld,
        input  s_arready, s_rvalid, s_r_pld,
        input  m_arvalid, m_arid, m_ar_pld, m_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N-master AXI4 read-channel arbiter: round-robin AR grant with per-master
// outstanding-burst limits, master-index ID tagging and R-beat routing by ID.
module axi_rd_arbiter #(
    parameter int NUM_M     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic              aclk,
    input  logic              reset,
    axi_rd_arbiter_if.master  bus,
    output logic              err_rid
);
    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int AR_W  = ADDR_W + 13;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t             state_r, state_n_s;
    logic [IDX_W-1:0]   ptr_r, ptr_n_s;
    logic [CNT_W-1:0]   cnt_r [NUM_M];
    logic               m_arvalid_r, m_arvalid_n_s;
    logic [ID_W-1:0]    m_arid_r, m_arid_n_s;
    logic [AR_W-1:0]    m_ar_pld_r, m_ar_pld_n_s;
    logic               err_rid_r;

    logic [NUM_M-1:0]   eligible_s, upper_s, inc_s, dec_s;
    logic [NUM_M-1:0]   s_arready_s, s_rvalid_s;
    logic               grant_vld_s, upper_vld_s;
    logic [IDX_W-1:0]   grant_idx_s, upper_idx_s, lower_idx_s;
    logic [AR_W-1:0]    grant_pld_s;
    logic [IDX_W-1:0]   rid_idx_s;
    logic               rid_in_range_s, route_ok_s, m_rready_s, r_last_s;
    logic [CNT_W-1:0]   rid_cnt_s;

    // Eligibility from the registered counters, split at the round-robin pointer
    always_comb begin
        eligible_s = '0;
        upper_s    = '0;
        for (int i = 0; i < NUM_M; i++) begin
            eligible_s[i] = bus.s_arvalid[i] && (cnt_r[i] < CNT_W'(MAX_OUTST));
            upper_s[i]    = eligible_s[i] && (IDX_W'(i) > ptr_r);
        end
    end

    // Grant: lowest eligible index above the pointer, else lowest eligible overall
    always_comb begin
        upper_idx_s = '0;
        lower_idx_s = '0;
        grant_pld_s = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            upper_idx_s = upper_s[i]    ? IDX_W'(i) : upper_idx_s;
            lower_idx_s = eligible_s[i] ? IDX_W'(i) : lower_idx_s;
        end
        upper_vld_s = |upper_s;
        grant_vld_s = |eligible_s;
        grant_idx_s = upper_vld_s ? upper_idx_s : lower_idx_s;
        for (int i = 0; i < NUM_M; i++) begin
            grant_pld_s = (IDX_W'(i) == grant_idx_s) ? bus.s_ar_pld[i*AR_W +: AR_W] : grant_pld_s;
        end
    end

    // Upstream AR ready: only in IDLE, one-hot on the granted master
    always_comb begin
        s_arready_s = '0;
        for (int i = 0; i < NUM_M; i++) begin
            s_arready_s[i] = (state_r == ST_IDLE) && !reset && grant_vld_s &&
                             (IDX_W'(i) == grant_idx_s);
        end
    end

    // AR FSM next-state and downstream AR register inputs
    always_comb begin
        state_n_s     = state_r;
        m_arvalid_n_s = m_arvalid_r;
        m_arid_n_s    = m_arid_r;
        m_ar_pld_n_s  = m_ar_pld_r;
        ptr_n_s       = ptr_r;
        inc_s         = '0;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_n_s     = ST_ISSUE;
                    m_arvalid_n_s = 1'b1;
                    m_arid_n_s    = ID_W'(grant_idx_s);
                    m_ar_pld_n_s  = grant_pld_s;
                    ptr_n_s       = grant_idx_s;
                    for (int i = 0; i < NUM_M; i++) begin
                        inc_s[i] = (IDX_W'(i) == grant_idx_s);
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.m_arready) begin
                    m_arvalid_n_s = 1'b0;
                    state_n_s     = ST_IDLE;
                end else begin
                    state_n_s = ST_ISSUE;
                end
            end
            default: begin
                state_n_s     = ST_IDLE;
                m_arvalid_n_s = 1'b0;
            end
        endcase
    end

    // AR FSM state, pointer and downstream AR registers
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= IDX_W'(NUM_M - 1);
            m_arvalid_r <= 1'b0;
            m_arid_r    <= '0;
            m_ar_pld_r  <= '0;
        end else begin
            state_r     <= state_n_s;
            ptr_r       <= ptr_n_s;
            m_arvalid_r <= m_arvalid_n_s;
            m_arid_r    <= m_arid_n_s;
            m_ar_pld_r  <= m_ar_pld_n_s;
        end
    end

    // R routing: a beat is only forwarded to a master that has a burst open
    always_comb begin
        rid_idx_s      = bus.m_rid[IDX_W-1:0];
        rid_in_range_s = (32'(bus.m_rid) < 32'(NUM_M));
        r_last_s       = bus.m_r_pld[0];
        rid_cnt_s      = '0;
        s_rvalid_s     = '0;
        dec_s          = '0;
        m_rready_s     = 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
            rid_cnt_s = (IDX_W'(i) == rid_idx_s) ? cnt_r[i] : rid_cnt_s;
        end
        route_ok_s = rid_in_range_s && (rid_cnt_s != '0);
        if (route_ok_s) begin
            for (int i = 0; i < NUM_M; i++) begin
                s_rvalid_s[i] = (IDX_W'(i) == rid_idx_s) && bus.m_rvalid;
                m_rready_s    = (IDX_W'(i) == rid_idx_s) ? bus.s_rready[i] : m_rready_s;
                dec_s[i]      = s_rvalid_s[i] && bus.s_rready[i] && r_last_s;
            end
        end else begin
            m_rready_s = 1'b1;
        end
    end

    // Outstanding-burst counters; simultaneous issue and completion cancel out
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_M; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                case ({inc_s[i], dec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Sticky flag for R beats that could not be routed to any master
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            err_rid_r <= 1'b0;
        end else if (bus.m_rvalid && !route_ok_s) begin
            err_rid_r <= 1'b1;
        end else begin
            err_rid_r <= err_rid_r;
        end
    end

    assign bus.s_arready = s_arready_s;
    assign bus.s_rvalid  = s_rvalid_s;
    assign bus.s_r_pld   = bus.m_r_pld;
    assign bus.m_rready  = m_rready_s;
    assign bus.m_arvalid = m_arvalid_r;
    assign bus.m_arid    = m_arid_r;
    assign bus.m_ar_pld  = m_ar_pld_r;
    assign err_rid       = err_rid_r;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of per-cycle vectors with
// hand-computed expectations, then sequences for unroutable IDs and reset.
module tb_axi_rd_arbiter;
    localparam int NUM_M     = 2;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int MAX_OUTST = 4;

    localparam logic [44:0] P0 = {32'hA000_1000, 8'd3,  3'd2, 2'd1};
    localparam logic [44:0] P1 = {32'hB000_2040, 8'd15, 3'd2, 2'd1};

    typedef struct {
        logic [1:0] arv;
        logic       ardy;
        logic       junk;
        logic       rv;
        logic [3:0] rid;
        logic       last;
        logic [1:0] srdy;
        logic [1:0] e_sardy;
        logic       e_mrdy;
        logic [1:0] e_srv;
        logic       e_arv;
        logic [3:0] e_arid;
    } vec_t;

    logic aclk;
    logic reset;
    logic err_rid;
    int   total = 0;
    int   bad   = 0;
    vec_t vq[$];
    logic [89:0] pld_all;

    axi_rd_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_rd_arbiter #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .aclk(aclk),
        .reset(reset),
        .bus(bus),
        .err_rid(err_rid)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] arv, input logic ardy, input logic junk,
                                input logic rv, input logic [3:0] rid, input logic last,
                                input logic [1:0] srdy, input logic [1:0] e_sardy,
                                input logic e_mrdy, input logic [1:0] e_srv,
                                input logic e_arv, input logic [3:0] e_arid);
        vec_t v;
        v.arv = arv; v.ardy = ardy; v.junk = junk; v.rv = rv; v.rid = rid; v.last = last;
        v.srdy = srdy; v.e_sardy = e_sardy; v.e_mrdy = e_mrdy; v.e_srv = e_srv;
        v.e_arv = e_arv; v.e_arid = e_arid;
        return v;
    endfunction

    initial begin
        vec_t        v;
        logic [34:0] rpld;
        logic [44:0] exp_pld;

        pld_all       = {P1, P0};
        reset         = 1'b1;
        bus.s_arvalid = 2'b11;
        bus.s_ar_pld  = pld_all;
        bus.s_rready  = 2'b00;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rid     = 4'd0;
        bus.m_r_pld   = 35'd0;
        repeat (2) @(posedge aclk);
        #1;
        check("reset s_arready", 64'(bus.s_arready), 64'd0);
        check("reset m_arvalid", 64'(bus.m_arvalid), 64'd0);
        check("reset m_arid", 64'(bus.m_arid), 64'd0);
        check("reset m_ar_pld", 64'(bus.m_ar_pld), 64'd0);
        check("reset err_rid", 64'(err_rid), 64'd0);
        bus.s_arvalid = 2'b00;
        reset         = 1'b0;

        // lone master 1 request, then ISSUE held 5 cycles with changing upstream payload
        vq.push_back(mk(2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b1, 4'd1));
        for (int k = 0; k < 5; k++) begin
            vq.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 4'd1));
        end
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 4'd1));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 1'b1, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        // alternating grants 1,0 until both masters hold four bursts
        for (int k = 0; k < 3; k++) begin
            vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 4'd1));
            vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd1));
            vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 4'd0));
            vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        end
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        // R: stalled beat for master 1, then last beat for master 0
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 4'd1));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 4'd1));
        // grant and completion on master 0 in the same cycle leave its count at 3
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        vq.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0));
        vq.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 4'd0));

        for (int r = 0; r < vq.size(); r++) begin
            v             = vq[r];
            rpld          = {32'h1000_0000 + 32'(r), 2'(r), v.last};
            bus.s_arvalid = v.arv;
            bus.m_arready = v.ardy;
            bus.s_ar_pld  = v.junk ? ~pld_all : pld_all;
            bus.m_rvalid  = v.rv;
            bus.m_rid     = v.rid;
            bus.m_r_pld   = rpld;
            bus.s_rready  = v.srdy;
            #1;
            check($sformatf("row%0d s_arready", r), 64'(bus.s_arready), 64'(v.e_sardy));
            check($sformatf("row%0d m_rready", r), 64'(bus.m_rready), 64'(v.e_mrdy));
            check($sformatf("row%0d s_rvalid", r), 64'(bus.s_rvalid), 64'(v.e_srv));
            check($sformatf("row%0d s_r_pld", r), 64'(bus.s_r_pld), 64'(rpld));
            @(posedge aclk);
            #1;
            check($sformatf("row%0d m_arvalid", r), 64'(bus.m_arvalid), 64'(v.e_arv));
            check($sformatf("row%0d m_arid", r), 64'(bus.m_arid), 64'(v.e_arid));
            check($sformatf("row%0d err_rid", r), 64'(err_rid), 64'd0);
            if (v.e_arv) begin
                exp_pld = (v.e_arid == 4'd1) ? P1 : P0;
                check($sformatf("row%0d m_ar_pld", r), 64'(bus.m_ar_pld), 64'(exp_pld));
            end
        end

        // unroutable beats: upper ID bit set, then ID beyond NUM_M
        bus.s_arvalid = 2'b11;
        bus.m_rvalid  = 1'b1;
        bus.m_rid     = 4'd4;
        bus.m_r_pld   = {32'hDEAD_0004, 2'b10, 1'b1};
        bus.s_rready  = 2'b00;
        #1;
        check("rid4 s_rvalid", 64'(bus.s_rvalid), 64'd0);
        check("rid4 m_rready", 64'(bus.m_rready), 64'd1);
        check("rid4 s_arready", 64'(bus.s_arready), 64'd0);
        @(posedge aclk);
        #1;
        check("rid4 err_rid", 64'(err_rid), 64'd1);
        bus.m_rid = 4'd3;
        #1;
        check("rid3 s_rvalid", 64'(bus.s_rvalid), 64'd0);
        check("rid3 m_rready", 64'(bus.m_rready), 64'd1);
        @(posedge aclk);
        #1;
        bus.m_rvalid = 1'b0;
        bus.m_rid    = 4'd0;
        #1;
        check("counters kept m_rready", 64'(bus.m_rready), 64'd0);
        check("counters kept s_arready", 64'(bus.s_arready), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("err_rid sticky", 64'(err_rid), 64'd1);

        // reset with outstanding bursts discards everything
        reset = 1'b1;
        #1;
        check("mid reset s_arready", 64'(bus.s_arready), 64'd0);
        check("mid reset err_rid", 64'(err_rid), 64'd0);
        check("mid reset m_ar_pld", 64'(bus.m_ar_pld), 64'd0);
        check("mid reset m_arvalid", 64'(bus.m_arvalid), 64'd0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        #1;
        check("post reset m_rready", 64'(bus.m_rready), 64'd1);
        check("post reset s_arready", 64'(bus.s_arready), 64'd1);
        @(posedge aclk);
        #1;
        check("post reset m_arvalid", 64'(bus.m_arvalid), 64'd1);
        check("post reset m_arid", 64'(bus.m_arid), 64'd0);
        check("post reset m_ar_pld", 64'(bus.m_ar_pld), 64'(P0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Parametrised N-master AXI4 read-channel arbiter. It sits between the MMU/cache read ports and the shared AXI4 read port that feeds the AXI4-to-AXI3 converter. Multiple inst/data/prefetch sources share one AR/R channel. It provides round-robin AR arbitration, per-master outstanding-burst limits, master-index ID tagging, and R-beat routing by ID.

Parameters:
NUM_M, 2, number of upstream masters (≥2); IDX_W = max(1, clog2(NUM_M)) derived
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, downstream ID width; must be ≥ IDX_W
MAX_OUTST, 4, max outstanding read bursts per master (≥1)

Ports:
aclk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
s_arvalid  in  NUM_M  per-master AR valid
s_arready  out  NUM_M  per-master AR ready, at most one bit set
s_ar_pld  in  NUM_M*(ADDR_W+13)  per master {addr, len[7:0], size[2:0], burst[1:0]}; master i at slice i
s_rvalid  out  NUM_M  per-master R valid, at most one bit set
s_rready  in  NUM_M  per-master R ready
s_r_pld  out  DATA_W+3  shared {data, resp[1:0], last}
m_arvalid  out  1  downstream AR valid
m_arready  in  1  downstream AR ready
m_arid  out  ID_W  {zeros, granted index}
m_ar_pld  out  ADDR_W+13  {addr, len, size, burst}
m_rvalid  in  1  downstream R valid
m_rready  out  1  downstream R ready
m_rid  in  ID_W  downstream R ID
m_r_pld  in  DATA_W+3  {data, resp, last}
err_rid  out  1  sticky: R beat received with an unroutable ID

Behaviour:
- Reset (async): m_arvalid=0, m_arid=0, m_ar_pld=0, state=IDLE, rr pointer=NUM_M-1 so master 0 has first priority, all counters=0, err_rid=0. While reset is high, s_arready=0.
- AR FSM, IDLE:
  - eligible[i] = s_arvalid[i] && cnt[i] < MAX_OUTST.
  - Grant g = first eligible index scanning ptr+1, ptr+2, … modulo NUM_M.
  - If any master is eligible: s_arready[g]=1 combinationally in the same cycle. On the clock edge, capture s_ar_pld[g] into m_ar_pld and g into m_arid, set m_arvalid=1, set ptr=g, increment cnt[g], and go to ISSUE.
- AR FSM, ISSUE:
  - All s_arready=0.
  - m_arvalid, m_arid and m_ar_pld are held stable.
  - On m_arready: m_arvalid=0, return to IDLE.
  - Maximum AR throughput is one request every 2 cycles.
- R path, combinational, zero latency:
  - idx = m_rid[IDX_W-1:0].
  - If m_rid < NUM_M and cnt[idx] > 0: s_rvalid[idx]=m_rvalid and m_rready=s_rready[idx].
  - s_r_pld = m_r_pld, broadcast to all masters.
  - Beats from different bursts may interleave at beat granularity; routing is per beat.
- Unroutable R beat (m_rid ≥ NUM_M, upper ID bits nonzero, or cnt[idx]==0): all s_rvalid=0, m_rready=1 (beat sunk), err_rid set to 1 and held until reset.
- Counters, width clog2(MAX_OUTST+1):
  - Decrement cnt[i] on m_rvalid && m_rready && last when the beat is routed to i.
  - A same-cycle increment and decrement on the same counter leaves it unchanged.
  - Counters never wrap: the issue gate prevents overflow and the routing check prevents underflow.
- Eligibility uses the registered cnt. A master at MAX_OUTST that completes a burst in cycle t can first be granted in cycle t+1.
- s_arready depends on s_arvalid. Upstream masters must not make s_arvalid depend on s_arready.
- Reset mid-burst discards all outstanding state. The downstream fabric must be reset by the same signal.

Test Plan:
- NUM_M=2, both s_arvalid held high, m_arready=1, R idle -> grants alternate 0,1,0,1; m_arid sequence 0,1,0,1; one m_arvalid pulse every 2 cycles; grants stop when cnt=4 for both.
- Only s_arvalid[1]=1 after reset -> s_arready[1]=1 in that cycle; next cycle m_arvalid=1, m_arid=1, m_ar_pld equals master 1 payload.
- m_arready held low 5 cycles during ISSUE -> m_ar_pld and m_arid stable, s_arready=0 throughout; new grant only in the cycle after acceptance.
- MAX_OUTST=4: master 0 issues 4 ARs with no R -> s_arready[0] stays 0 while master 1 is still granted. R beat with rid=0, last=1 -> master 0 granted on a following IDLE cycle.
- Interleaved R: rid=1 beat with s_rready[1]=0 -> m_rready=0, s_rvalid=2'b10, data stable. Next, rid=0 beat with s_rready[0]=1 -> s_rvalid=2'b01, m_rready=1.
- rid=3 with NUM_M=2, m_rvalid=1 -> m_rready=1, s_rvalid=0, err_rid=1 and held until reset; counters unchanged.
